// File: rtl/decoder.sv
// 2-to-4 line decoder with selectable output polarity and an optional
// output register stage with asynchronous reset.
module decoder #(
  parameter bit REG_OUT     = 1'b0,
  parameter bit ACTIVE_HIGH = 1'b1
) (
  input  logic CLK,
  input  logic RST,
  input  logic D0,
  input  logic D1,
  output logic A0,
  output logic A1,
  output logic A2,
  output logic A3
);

  // "None selected" value: no output asserted in the chosen polarity.
  localparam logic [3:0] IDLE = ACTIVE_HIGH ? 4'b0000 : 4'b1111;

  logic [3:0] dec_p0;
  logic [3:0] dec_out;

  function automatic logic [3:0] polarize(input logic [3:0] v);
    return ACTIVE_HIGH ? v : ~v;
  endfunction

  // Stage p0: combinational one-hot decode, bit i drives Ai.
  always_comb begin
    dec_p0    = 4'b0000;
    dec_p0[0] = ~D0 & ~D1;
    dec_p0[1] = ~D0 &  D1;
    dec_p0[2] =  D0 & ~D1;
    dec_p0[3] =  D0 &  D1;
  end

  generate
    if (REG_OUT) begin : g_reg
      logic [3:0] dec_p1;

      // Stage p1: registered outputs, reset forces the idle pattern.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          dec_p1 <= IDLE;
        end else begin
          dec_p1 <= polarize(dec_p0);
        end
      end

      assign dec_out = dec_p1;
    end else begin : g_comb
      // Clock and reset are unused in the combinational build.
      logic unused_clk_rst;
      assign unused_clk_rst = CLK ^ RST;
      assign dec_out        = polarize(dec_p0);
    end
  endgenerate

  assign A0 = dec_out[0];
  assign A1 = dec_out[1];
  assign A2 = dec_out[2];
  assign A3 = dec_out[3];

endmodule

// File: tb/tb_decoder.sv
// Bench for decoder: four builds (comb/registered x both polarities),
// expectations queued on drive and compared when the outputs are sampled.
module tb_decoder;

  typedef struct {
    string      tag;
    logic [3:0] exp;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   fails = 0;

  logic clk = 1'b0;
  logic rrst = 1'b1;
  logic irst = 1'b1;
  logic [1:0] cd = 2'b00;
  logic [1:0] rd = 2'b11;
  logic [1:0] id = 2'b11;

  logic c_a0, c_a1, c_a2, c_a3;
  logic n_a0, n_a1, n_a2, n_a3;
  logic r_a0, r_a1, r_a2, r_a3;
  logic i_a0, i_a1, i_a2, i_a3;

  // Observed vectors printed as A0..A3, left to right.
  logic [3:0] comb_o, inv_o, reg_o, reginv_o;
  assign comb_o   = {c_a0, c_a1, c_a2, c_a3};
  assign inv_o    = {n_a0, n_a1, n_a2, n_a3};
  assign reg_o    = {r_a0, r_a1, r_a2, r_a3};
  assign reginv_o = {i_a0, i_a1, i_a2, i_a3};

  always #5 clk = ~clk;

  decoder #(.REG_OUT(1'b0), .ACTIVE_HIGH(1'b1)) u_comb (
    .CLK(clk), .RST(rrst), .D0(cd[1]), .D1(cd[0]),
    .A0(c_a0), .A1(c_a1), .A2(c_a2), .A3(c_a3)
  );

  decoder #(.REG_OUT(1'b0), .ACTIVE_HIGH(1'b0)) u_inv (
    .CLK(clk), .RST(irst), .D0(cd[1]), .D1(cd[0]),
    .A0(n_a0), .A1(n_a1), .A2(n_a2), .A3(n_a3)
  );

  decoder #(.REG_OUT(1'b1), .ACTIVE_HIGH(1'b1)) u_reg (
    .CLK(clk), .RST(rrst), .D0(rd[1]), .D1(rd[0]),
    .A0(r_a0), .A1(r_a1), .A2(r_a2), .A3(r_a3)
  );

  decoder #(.REG_OUT(1'b1), .ACTIVE_HIGH(1'b0)) u_reginv (
    .CLK(clk), .RST(irst), .D0(id[1]), .D1(id[0]),
    .A0(i_a0), .A1(i_a1), .A2(i_a2), .A3(i_a3)
  );

  // Reference: A0..A3 pattern for a select value, optionally inverted.
  function automatic logic [3:0] model(input logic [1:0] sel, input bit ah);
    logic [3:0] m;
    m = 4'b1000 >> sel;
    return ah ? m : ~m;
  endfunction

  task automatic expect_val(input string tag, input logic [3:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic check(input logic [3:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty: observed %b required an expectation", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        fails++;
        $error("FAIL %s: observed %b expected %b", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic check_onehot(input logic [3:0] obs);
    total++;
    assert ($countones(obs) == 1) else begin
      fails++;
      $error("FAIL onehot: observed %b expected exactly one bit set", obs);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Combinational builds, directed select sweep at 20-unit intervals.
    for (int s = 0; s < 4; s++) begin
      cd = s[1:0];
      expect_val($sformatf("comb_dir_%0d", s), model(s[1:0], 1'b1));
      expect_val($sformatf("inv_dir_%0d", s), model(s[1:0], 1'b0));
      #1;
      check(comb_o);
      check(inv_o);
      #19;
    end

    // Random toggling of the combinational build.
    for (int k = 0; k < 24; k++) begin
      cd = 2'($urandom_range(0, 3));
      expect_val($sformatf("comb_rand_%0d", k), model(cd, 1'b1));
      #1;
      check(comb_o);
      check_onehot(comb_o);
      #9;
    end

    // Registered, active-high: reset hold ignores clock and D.
    @(negedge clk);
    expect_val("reg_rst_hold", 4'b0000);
    expect_val("reginv_rst_hold", 4'b1111);
    check(reg_o);
    check(reginv_o);

    // Release reset; nothing changes until the next rising edge.
    rrst = 1'b0;
    rd   = 2'b10;
    irst = 1'b0;
    id   = 2'b00;
    expect_val("reg_pre_edge", 4'b0000);
    expect_val("reginv_pre_edge", 4'b1111);
    expect_val("reg_first_cap", 4'b0010);
    expect_val("reginv_first_cap", 4'b0111);
    #1;
    check(reg_o);
    check(reginv_o);
    @(negedge clk);
    check(reg_o);
    check(reginv_o);

    // One-cycle latency on a select change.
    rd = 2'b11;
    expect_val("reg_lat_hold", 4'b0010);
    expect_val("reg_lat_11", 4'b0001);
    #1;
    check(reg_o);
    @(negedge clk);
    check(reg_o);

    rd = 2'b01;
    expect_val("reg_sel_01", 4'b0100);
    @(negedge clk);
    check(reg_o);

    // Mid-cycle reset pulse: immediate clear, recovery on next edge.
    #1;
    rrst = 1'b1;
    expect_val("reg_async_clr", 4'b0000);
    expect_val("reg_clr_held", 4'b0000);
    expect_val("reg_recover", 4'b0100);
    #1;
    check(reg_o);
    rrst = 1'b0;
    #1;
    check(reg_o);
    @(negedge clk);
    check(reg_o);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/decoder.md
# decoder

2-to-4 line decoder that turns a 2-bit select (D0, D1) into four one-hot outputs (A0..A3). It is a leaf utility block for address and enable decoding in small datapaths. The default build is purely combinational. A parameter can add an output register stage on the shared clock with asynchronous reset.

## Interface

Parameters:
- REG_OUT, default 0: 0 means combinational outputs and CLK/RST are unused; 1 means the outputs are registered (1-cycle latency).
- ACTIVE_HIGH, default 1: 1 means the selected output is 1 and the others are 0; 0 means the outputs are inverted (selected output is 0, the others are 1).

Ports:
- CLK, input, 1: the single clock, rising-edge; used only when REG_OUT=1.
- RST, input, 1: asynchronous, active-high reset; used only when REG_OUT=1.
- D0, input, 1: select MSB.
- D1, input, 1: select LSB.
- A0, output, 1: asserted when {D0,D1}=00.
- A1, output, 1: asserted when {D0,D1}=01.
- A2, output, 1: asserted when {D0,D1}=10.
- A3, output, 1: asserted when {D0,D1}=11.

Clock and reset: one clock; reset is asynchronous and active-high.

## Operation

- Select index is sel = {D0,D1}, with D0 as the MSB.
- Decode with ACTIVE_HIGH=1:
  - A0 = ~D0 & ~D1
  - A1 = ~D0 & D1
  - A2 = D0 & ~D1
  - A3 = D0 & D1
- Exactly one output is asserted for every defined input. The outputs are always one-hot (or one-cold when ACTIVE_HIGH=0).
- ACTIVE_HIGH=0: each output is the bitwise inverse of its ACTIVE_HIGH=1 value.
- X/Z on D0 or D1: outputs may go X. No X-masking is required.
- REG_OUT=0:
  - No state is held.
  - CLK and RST have no effect and may be left unconnected.
- REG_OUT=1:
  - The decoded vector is captured in a 4-bit register on the rising edge of CLK.
  - A0..A3 are driven from that register.
- Reset applies when REG_OUT=1 only:
  - RST high immediately and asynchronously forces the register to its "none selected" value: all 0 when ACTIVE_HIGH=1, all 1 when ACTIVE_HIGH=0.
  - While RST is high, the register holds that value regardless of CLK and D.
  - While RST is high the outputs are not one-hot. This is the only state in which that is permitted.

## Timing

- REG_OUT=0: outputs follow D0/D1 after propagation delay only; zero latency.
- REG_OUT=1, latency: an input change present before rising edge N appears on A0..A3 after edge N (1 cycle).
- REG_OUT=1, reset release:
  - RST deasserts asynchronously.
  - The first capture happens at the first rising edge at which RST is low.
  - Outputs stay at the reset value until that edge.
- Reset asserted mid-operation: outputs go to the reset value within the same cycle, without waiting for a clock edge.
- Inputs are not internally synchronized. The integrator guarantees setup/hold when REG_OUT=1.

## Test plan

- Default build (REG_OUT=0, ACTIVE_HIGH=1), CLK/RST unconnected; apply D0D1 = 00, 01, 10, 11 at 20-unit intervals:
  - 00 gives A0..A3 = 1000.
  - 01 gives 0100.
  - 10 gives 0010.
  - 11 gives 0001.
  - Each must be correct within the same time step.
- Default build, exhaustive random toggling of D0/D1: exactly one of A0..A3 is high at every sample, and its index equals {D0,D1}.
- ACTIVE_HIGH=0, apply all 4 combinations: 00 gives 0111, 01 gives 1011, 10 gives 1101, 11 gives 1110.
- REG_OUT=1, reset behaviour:
  - Hold RST=1: outputs are 0000.
  - Release RST and set D0D1=10: outputs stay 0000 until the next rising edge, then become 0010.
  - Change to 11: 0001 appears exactly one edge later.
- REG_OUT=1 with D0D1=01 and outputs at 0100; pulse RST high between clock edges: outputs drop to 0000 immediately, and return to 0100 on the first rising edge after RST falls.
- REG_OUT=1, ACTIVE_HIGH=0, RST high: outputs are 1111; after release with D0D1=00, outputs become 0111 on the next edge.
